// File: rtl/alu_logic_iter.sv
// Multi-cycle logic/shift/count-leading ALU slice with valid/ready on both sides.
// Logic ops complete in one cycle; shifts and CLZ/CLO walk SHIFT_STEP bits per cycle.
module alu_logic_iter #(
  parameter int N          = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  input  logic [$clog2(N)-1:0] sa,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         y
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // SHIFT | shifting/rotating y by up to SHIFT_STEP bits per cycle
  // SCAN  | examining the top SHIFT_STEP bits of w per cycle
  // DONE  | result held on y with out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, SCAN, DONE} state_t;

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] N_C    = CW'(N);

  state_t         state, state_next;
  logic [3:0]     op_q, op_next;
  logic [N-1:0]   y_next, w, w_next;
  logic [CW-1:0]  rem, rem_next, cnt, cnt_next, k, lz;
  logic [2*N-1:0] rot;

  function automatic logic [CW-1:0] chunk_lz(input logic [SHIFT_STEP-1:0] c);
    logic found;
    chunk_lz = '0;
    found    = 1'b0;
    for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
      if (!found) begin
        if (c[i]) found = 1'b1;
        else      chunk_lz = chunk_lz + CW'(1);
      end
    end
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      y     <= '0;
      w     <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      op_q  <= op_next;
      y     <= y_next;
      w     <= w_next;
      rem   <= rem_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    y_next     = y;
    w_next     = w;
    rem_next   = rem;
    cnt_next   = cnt;
    k          = (rem < STEP_C) ? rem : STEP_C;
    lz         = chunk_lz(w[N-1 -: SHIFT_STEP]);
    rot        = {y, y} >> k;

    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          op_next  = op;
          rem_next = {1'b0, sa};
          cnt_next = '0;
          case (op)
            4'd0: begin y_next = a & b;    state_next = DONE; end
            4'd1: begin y_next = a | b;    state_next = DONE; end
            4'd2: begin y_next = a ^ b;    state_next = DONE; end
            4'd3: begin y_next = ~(a | b); state_next = DONE; end
            4'd4, 4'd5, 4'd6, 4'd7: begin
              y_next     = b;
              state_next = (sa != '0) ? SHIFT : DONE;
            end
            4'd8: begin w_next = a;  state_next = SCAN; end
            4'd9: begin w_next = ~a; state_next = SCAN; end
            default: begin y_next = '0; state_next = DONE; end
          endcase
        end
      end
      SHIFT: begin
        case (op_q)
          4'd4:    y_next = y << k;
          4'd5:    y_next = y >> k;
          4'd6:    y_next = $unsigned($signed(y) >>> k);
          default: y_next = rot[N-1:0];
        endcase
        rem_next = rem - k;
        if (rem_next == '0) state_next = DONE;
      end
      SCAN: begin
        if (w[N-1 -: SHIFT_STEP] != '0) begin
          y_next     = {{(N-CW){1'b0}}, cnt + lz};
          state_next = DONE;
        end else begin
          cnt_next = cnt + STEP_C;
          w_next   = w << SHIFT_STEP;
          // all chunks zero: the count saturates at N
          if (cnt_next == N_C) begin
            y_next     = {{(N-CW){1'b0}}, N_C};
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) state_next = IDLE;
  end

endmodule
